// File: rtl/alarm_clock.sv
// alarm_clock: prescaled HH:MM:SS time base with a load handshake, one alarm
// with acknowledge/timeout, and a registered 12/24-hour display.
//
// state | meaning
// IDLE  | alarm silent; match against alarm time checked on every tick
// RING  | alarm asserted until ack, disarm, reset or ALARM_SEC ticks
module alarm_clock #(
    parameter int CLK_FREQ_HZ  = 50_000,
    parameter int TICK_FREQ_HZ = 1,
    parameter int SEC_VALUE    = 60,
    parameter int MIN_VALUE    = 60,
    parameter int HOUR_VALUE   = 24,
    parameter int ALARM_SEC    = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          set_valid,
    output logic                          set_ready,
    input  logic [$clog2(HOUR_VALUE)-1:0] set_hour,
    input  logic [$clog2(MIN_VALUE)-1:0]  set_min,
    input  logic [$clog2(SEC_VALUE)-1:0]  set_sec,
    output logic                          set_err,
    input  logic                          alm_wr,
    input  logic [$clog2(HOUR_VALUE)-1:0] alm_hour,
    input  logic [$clog2(MIN_VALUE)-1:0]  alm_min,
    input  logic                          alm_en,
    input  logic                          alm_ack,
    input  logic                          mode_12h,
    output logic [$clog2(SEC_VALUE)-1:0]  out_sec,
    output logic [$clog2(MIN_VALUE)-1:0]  out_min,
    output logic [$clog2(HOUR_VALUE)-1:0] out_hour,
    output logic                          out_pm,
    output logic                          tick,
    output logic                          alarm
);

    localparam int DIV = CLK_FREQ_HZ / TICK_FREQ_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int SW  = $clog2(SEC_VALUE);
    localparam int MW  = $clog2(MIN_VALUE);
    localparam int HW  = $clog2(HOUR_VALUE);
    localparam int RW  = $clog2(ALARM_SEC + 1);

    localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_VALUE - 1);
    localparam logic [MW-1:0] MIN_MAX   = MW'(MIN_VALUE - 1);
    localparam logic [HW-1:0] HOUR_MAX  = HW'(HOUR_VALUE - 1);
    localparam logic [HW-1:0] NOON      = HW'(12);
    localparam logic [RW-1:0] RING_LAST = RW'(ALARM_SEC - 1);
    localparam bit            HAS_12H   = (HOUR_VALUE == 24);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RING = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] ring_cnt_q, ring_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] sec_q, sec_d;
    logic [MW-1:0] min_q, min_d;
    logic [HW-1:0] hour_q, hour_d;
    logic [HW-1:0] alm_hour_q, alm_hour_d;
    logic [MW-1:0] alm_min_q, alm_min_d;
    logic [HW-1:0] out_hour_q, out_hour_d;
    logic          out_pm_q, out_pm_d;
    logic          set_ready_q, set_ready_d;
    logic          set_err_q, set_err_d;
    logic          tick_q, tick_d;

    logic accept, set_in_range, load, wrap, alm_match;

    // Time base, load handshake and alarm registers
    always_comb begin
        accept       = set_valid && set_ready_q;
        set_in_range = (set_hour <= HOUR_MAX) && (set_min <= MIN_MAX) && (set_sec <= SEC_MAX);
        load         = accept && set_in_range;
        wrap         = run && (presc_q == PRE_MAX);
        tick_d       = wrap && !load;
        set_ready_d  = !accept;
        set_err_d    = accept && !set_in_range;

        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        if (load) begin
            presc_d = '0;
            sec_d   = set_sec;
            min_d   = set_min;
            hour_d  = set_hour;
        end else if (run) begin
            presc_d = wrap ? '0 : presc_q + PW'(1);
            if (wrap) begin
                if (sec_q == SEC_MAX) begin
                    sec_d = '0;
                    if (min_q == MIN_MAX) begin
                        min_d  = '0;
                        hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + HW'(1);
                    end else begin
                        min_d = min_q + MW'(1);
                    end
                end else begin
                    sec_d = sec_q + SW'(1);
                end
            end
        end

        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
        if (alm_wr && (alm_hour <= HOUR_MAX) && (alm_min <= MIN_MAX)) begin
            alm_hour_d = alm_hour;
            alm_min_d  = alm_min;
        end

        // Matched against the time about to appear so alarm rises with it
        alm_match = alm_en && tick_d && (hour_d == alm_hour_q) &&
                    (min_d == alm_min_q) && (sec_d == '0);
    end

    // Display conversion from the next internal hour keeps hour and sec aligned
    always_comb begin
        out_hour_d = hour_d;
        out_pm_d   = 1'b0;
        if (mode_12h && HAS_12H) begin
            out_pm_d = (hour_d >= NOON);
            if (hour_d == '0) begin
                out_hour_d = NOON;
            end else if (hour_d > NOON) begin
                out_hour_d = hour_d - NOON;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            alm_hour_q  <= '0;
            alm_min_q   <= '0;
            out_hour_q  <= '0;
            out_pm_q    <= 1'b0;
            set_ready_q <= 1'b0;
            set_err_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
            out_hour_q  <= out_hour_d;
            out_pm_q    <= out_pm_d;
            set_ready_q <= set_ready_d;
            set_err_q   <= set_err_d;
            tick_q      <= tick_d;
        end
    end

    // Alarm FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
        end
    end

    // Alarm FSM: next state
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (alm_match) begin
                    state_d    = ST_RING;
                    ring_cnt_d = '0;
                end
            end
            ST_RING: begin
                if (alm_ack || !alm_en) begin
                    state_d = ST_IDLE;
                end else if (tick_d) begin
                    if (ring_cnt_q == RING_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        ring_cnt_d = ring_cnt_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Alarm FSM: outputs
    always_comb begin
        alarm = (state_q == ST_RING);
    end

    assign set_ready = set_ready_q;
    assign set_err   = set_err_q;
    assign tick      = tick_q;
    assign out_sec   = sec_q;
    assign out_min   = min_q;
    assign out_hour  = out_hour_q;
    assign out_pm    = out_pm_q;

endmodule

// File: tb/tb_alarm_clock.sv
// Directed bench for alarm_clock with DIV = 4 and ALARM_SEC = 3: a per-cycle
// vector table for reset/load/12h behaviour, then hand-written alarm sequences.
module tb_alarm_clock;

    logic       clk = 1'b0;
    logic       reset, run, set_valid, set_ready, set_err;
    logic [4:0] set_hour, alm_hour, out_hour;
    logic [5:0] set_min, set_sec, alm_min, out_sec, out_min;
    logic       alm_wr, alm_en, alm_ack, mode_12h, out_pm, tick, alarm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alarm_clock #(
        .CLK_FREQ_HZ (4),
        .TICK_FREQ_HZ(1),
        .SEC_VALUE   (60),
        .MIN_VALUE   (60),
        .HOUR_VALUE  (24),
        .ALARM_SEC   (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .set_valid(set_valid),
        .set_ready(set_ready),
        .set_hour (set_hour),
        .set_min  (set_min),
        .set_sec  (set_sec),
        .set_err  (set_err),
        .alm_wr   (alm_wr),
        .alm_hour (alm_hour),
        .alm_min  (alm_min),
        .alm_en   (alm_en),
        .alm_ack  (alm_ack),
        .mode_12h (mode_12h),
        .out_sec  (out_sec),
        .out_min  (out_min),
        .out_hour (out_hour),
        .out_pm   (out_pm),
        .tick     (tick),
        .alarm    (alarm)
    );

    typedef struct packed {
        logic       rst;
        logic       run;
        logic       sv;
        logic [4:0] sh;
        logic [5:0] sm;
        logic [5:0] ss;
        logic       mode;
        logic [4:0] e_hour;
        logic [5:0] e_min;
        logic [5:0] e_sec;
        logic       e_pm;
        logic       e_tick;
        logic       e_rdy;
        logic       e_err;
    } vec_t;

    vec_t vt [21];

    function automatic vec_t mk(input logic rst, input logic rn, input logic sv,
                                input int sh, input int sm, input int ss, input logic mode,
                                input int eh, input int em, input int es,
                                input logic epm, input logic etk, input logic erd, input logic eer);
        vec_t v;
        v.rst = rst;  v.run = rn;  v.sv = sv;
        v.sh = 5'(sh); v.sm = 6'(sm); v.ss = 6'(ss); v.mode = mode;
        v.e_hour = 5'(eh); v.e_min = 6'(em); v.e_sec = 6'(es);
        v.e_pm = epm; v.e_tick = etk; v.e_rdy = erd; v.e_err = eer;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic chk_time(input string name, input int h, input int m, input int s);
        chk(name, {15'd0, out_hour, out_min, out_sec}, {15'd0, 5'(h), 6'(m), 6'(s)});
    endtask

    task automatic load(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
        cyc();
        set_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        logic [31:0] act, exp;

        reset = 1'b1; run = 1'b0; set_valid = 1'b0;
        set_hour = '0; set_min = '0; set_sec = '0;
        alm_wr = 1'b0; alm_hour = '0; alm_min = '0;
        alm_en = 1'b0; alm_ack = 1'b0; mode_12h = 1'b0;

        //            rst run sv  sh  sm  ss mode | hour min sec pm tick rdy err
        vt[0]  = mk(1, 0, 0,  0,  0,  0, 0,    0,  0,  0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0,  0,  0,  0, 0,    0,  0,  0, 0, 0, 1, 0);
        vt[2]  = mk(0, 0, 0,  0,  0,  0, 1,   12,  0,  0, 0, 0, 1, 0);
        vt[3]  = mk(0, 0, 1, 12,  0,  0, 1,   12,  0,  0, 1, 0, 0, 0);
        vt[4]  = mk(0, 0, 1, 13,  5,  7, 1,   12,  0,  0, 1, 0, 1, 0);
        vt[5]  = mk(0, 0, 1, 13,  5,  7, 1,    1,  5,  7, 1, 0, 0, 0);
        vt[6]  = mk(0, 0, 0,  0,  0,  0, 0,   13,  5,  7, 0, 0, 1, 0);
        vt[7]  = mk(0, 0, 1, 10,  0, 60, 0,   13,  5,  7, 0, 0, 0, 1);
        vt[8]  = mk(0, 0, 0,  0,  0,  0, 0,   13,  5,  7, 0, 0, 1, 0);
        vt[9]  = mk(0, 0, 1, 24,  0,  0, 0,   13,  5,  7, 0, 0, 0, 1);
        vt[10] = mk(0, 0, 0,  0,  0,  0, 0,   13,  5,  7, 0, 0, 1, 0);
        vt[11] = mk(0, 0, 1, 23, 59, 59, 1,   11, 59, 59, 1, 0, 0, 0);
        vt[12] = mk(0, 0, 1,  0, 60,  0, 1,   11, 59, 59, 1, 0, 1, 0);
        vt[13] = mk(0, 0, 1,  0, 60,  0, 1,   11, 59, 59, 1, 0, 0, 1);
        vt[14] = mk(0, 1, 0,  0,  0,  0, 1,   11, 59, 59, 1, 0, 1, 0);
        vt[15] = mk(0, 1, 0,  0,  0,  0, 1,   11, 59, 59, 1, 0, 1, 0);
        vt[16] = mk(0, 1, 0,  0,  0,  0, 1,   11, 59, 59, 1, 0, 1, 0);
        vt[17] = mk(0, 1, 0,  0,  0,  0, 1,   12,  0,  0, 0, 1, 1, 0);
        vt[18] = mk(0, 0, 0,  0,  0,  0, 1,   12,  0,  0, 0, 0, 1, 0);
        vt[19] = mk(1, 1, 0,  0,  0,  0, 1,    0,  0,  0, 0, 0, 0, 0);
        vt[20] = mk(0, 0, 0,  0,  0,  0, 0,    0,  0,  0, 0, 0, 1, 0);

        for (int i = 0; i < 21; i++) begin
            reset     = vt[i].rst;
            run       = vt[i].run;
            set_valid = vt[i].sv;
            set_hour  = vt[i].sh;
            set_min   = vt[i].sm;
            set_sec   = vt[i].ss;
            mode_12h  = vt[i].mode;
            cyc();
            act = {10'd0, out_hour, out_min, out_sec, out_pm, tick, set_ready, set_err, alarm};
            exp = {10'd0, vt[i].e_hour, vt[i].e_min, vt[i].e_sec, vt[i].e_pm,
                   vt[i].e_tick, vt[i].e_rdy, vt[i].e_err, 1'b0};
            chk($sformatf("vec%0d", i), act, exp);
        end
        set_valid = 1'b0; run = 1'b0; mode_12h = 1'b0; reset = 1'b0;

        // Rollover through midnight, then freeze
        load(23, 59, 58);
        chk_time("roll_load", 23, 59, 58);
        run = 1'b1;
        ticks = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (tick) ticks++;
            if (k == 4) chk_time("roll_59", 23, 59, 59);
            if (k == 8) chk_time("roll_mid", 0, 0, 0);
        end
        chk("roll_ticks", ticks, 2);
        run = 1'b0;
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (tick) ticks++;
        end
        chk("frozen_ticks", ticks, 0);
        chk_time("frozen_time", 0, 0, 0);

        // Load on the prescaler's terminal cycle suppresses the tick
        run = 1'b1;
        for (int k = 0; k < 3; k++) cyc();
        load(5, 6, 7);
        chk_time("lwin_time", 5, 6, 7);
        chk("lwin_tick", tick, 0);
        chk("lwin_rdy", set_ready, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("lwin_tick%0d", k), tick, (k == 4));
        end
        chk_time("lwin_next", 5, 6, 8);
        run = 1'b0;

        // Alarm timeout after three ticks
        alm_wr = 1'b1; alm_hour = 5'd7; alm_min = 6'd30; alm_en = 1'b1;
        cyc();
        alm_wr = 1'b0;
        load(7, 29, 59);
        chk("to_load_alarm", alarm, 0);
        run = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            chk($sformatf("to_alarm%0d", k), alarm, (k >= 4 && k < 16));
            if (k % 4 == 0) chk_time($sformatf("to_time%0d", k), 7, 30, k / 4 - 1);
        end
        run = 1'b0;

        // Acknowledge at 07:30:01, no retrigger at 07:30:02
        load(7, 29, 59);
        run = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            chk($sformatf("ack_alarm%0d", k), alarm, (k >= 4 && k <= 8));
            if (k == 8) begin
                chk_time("ack_time", 7, 30, 1);
                alm_ack = 1'b1;
            end
            if (k == 9) alm_ack = 1'b0;
        end
        run = 1'b0;

        // Out-of-range alarm writes ignored; in-range write keeps ringing; disarm stops it
        alm_wr = 1'b1; alm_hour = 5'd24; alm_min = 6'd0;
        cyc();
        alm_hour = 5'd7; alm_min = 6'd60;
        cyc();
        alm_wr = 1'b0;
        load(7, 29, 59);
        run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk($sformatf("wr_alarm%0d", k), alarm, (k >= 4 && k <= 6));
            if (k == 5) begin
                alm_wr = 1'b1; alm_hour = 5'd8; alm_min = 6'd0;
            end
            if (k == 6) begin
                alm_wr = 1'b0; alm_en = 1'b0;
            end
        end
        run = 1'b0;

        // A load landing exactly on the alarm time does not ring
        alm_en = 1'b1;
        alm_wr = 1'b1; alm_hour = 5'd7; alm_min = 6'd30;
        cyc();
        alm_wr = 1'b0;
        load(7, 30, 0);
        chk_time("ld_noalarm_time", 7, 30, 0);
        chk("ld_noalarm0", alarm, 0);
        cyc();
        chk("ld_noalarm1", alarm, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_clock.md
Name: alarm_clock

Overview:
- Parametrised successor to the team's free-running digital_clock.
- Adds run/pause, a time-load handshake with range checking, one programmable alarm with acknowledge and timeout, and a 12/24-hour display mode.
- Sits between the system clock domain and display/UI logic.
- A clock-enable prescaler derives the time base from clk; no derived clocks.

Parameters:
- CLK_FREQ_HZ, 50_000, input clock frequency.
- TICK_FREQ_HZ, 1, time-advance rate; DIV = CLK_FREQ_HZ/TICK_FREQ_HZ, must be >= 2.
- SEC_VALUE, 60, seconds modulus.
- MIN_VALUE, 60, minutes modulus.
- HOUR_VALUE, 24, hours modulus; 12h mode is defined only for 24.
- ALARM_SEC, 10, alarm ring duration in ticks, >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = prescaler counts; 0 = frozen.
- set_valid  in  1  time-load request.
- set_ready  out  1  load accept.
- set_hour  in  $clog2(HOUR_VALUE)  hour to load.
- set_min  in  $clog2(MIN_VALUE)  minute to load.
- set_sec  in  $clog2(SEC_VALUE)  second to load.
- set_err  out  1  one-cycle pulse when a load is rejected.
- alm_wr  in  1  write alarm registers.
- alm_hour  in  $clog2(HOUR_VALUE)  alarm hour.
- alm_min  in  $clog2(MIN_VALUE)  alarm minute.
- alm_en  in  1  alarm arm.
- alm_ack  in  1  silence alarm.
- mode_12h  in  1  display format select.
- out_sec  out  $clog2(SEC_VALUE)  seconds.
- out_min  out  $clog2(MIN_VALUE)  minutes.
- out_hour  out  $clog2(HOUR_VALUE)  hours (display format).
- out_pm  out  1  PM flag; 0 in 24h mode.
- tick  out  1  one-cycle pulse per time advance.
- alarm  out  1  high while ringing.

Behaviour:
- Reset (sync, any time, including mid-load or mid-ring):
  - Time = 00:00:00, prescaler = 0, alarm registers = 00:00.
  - FSM = IDLE.
  - All outputs 0, including set_ready, tick, set_err, alarm, out_pm.
  - The first cycle after reset deasserts, set_ready = 1.
- Prescaler:
  - With run = 1, the prescaler counts 0..DIV-1.
  - On the cycle it equals DIV-1, it wraps to 0 and the time advances by one second.
  - The new time and the tick pulse are visible on the next clock edge together.
  - run = 0 holds both prescaler and time.
- Rollover:
  - sec SEC_VALUE-1 -> 0 carries into minutes.
  - min MIN_VALUE-1 -> 0 carries into hours.
  - hour HOUR_VALUE-1 -> 0.
  - 23:59:59 -> 00:00:00 in a single tick.
- Load handshake:
  - A load is accepted on set_valid && set_ready.
  - set_ready drops for exactly one cycle after each accept.
  - In range (hour < HOUR_VALUE, min < MIN_VALUE, sec < SEC_VALUE):
    - Time is loaded next edge and the prescaler is cleared to 0.
    - Any tick in that cycle is suppressed; load wins.
  - Out of range:
    - Time and prescaler are unchanged.
    - set_err pulses one cycle; it is still a handshake, so set_ready drops.
  - A load never triggers the alarm.
- Alarm write:
  - alm_wr loads alm_hour/alm_min when both are in range; otherwise it is ignored.
  - A write during RING does not stop ringing.
- Alarm FSM:
  - IDLE -> RING: on a tick whose new time equals alm_hour:alm_min:00 while alm_en = 1.
    - alarm rises in the same cycle the matching time appears on the outputs.
    - Ring counter = 0.
  - RING -> IDLE, on whichever comes first:
    - alm_ack = 1;
    - alm_en = 0;
    - reset;
    - ALARM_SEC ticks counted after entry. alarm falls in the same cycle as the ALARM_SEC-th tick output.
  - Exit is registered: alarm is low from the next edge.
  - alm_ack in IDLE has no effect.
  - The match is evaluated only on tick, so an armed alarm fires at most once per matching minute.
- 12h display:
  - mode_12h = 1 with internal hour h:
    - out_hour = 12 if h = 0;
    - h-12 if h > 12;
    - else h.
    - out_pm = (h >= 12).
  - Outputs are registered; a mode_12h change is visible one cycle later.
  - The internal count is always 24h.
- Widths: all arithmetic is at port widths; no overflow is possible within the legal ranges.

Test Plan:
- Common setup: CLK_FREQ_HZ = 4, TICK_FREQ_HZ = 1 (DIV = 4), ALARM_SEC = 3 unless stated.
- Reset mid-run: run for 4 ticks, then assert reset for 1 cycle -> all outputs 0 next edge; set_ready = 1 the cycle after release.
- Rollover: load 23:59:58, run = 1 -> 23:59:59 after 4 clocks, then 00:00:00 after 8 clocks, tick high exactly 2 cycles total; run = 0 for 10 clocks -> time frozen, no tick.
- Load checks:
  - set_sec = 60 -> set_err = 1 for 1 cycle, time unchanged, set_ready low 1 cycle.
  - Valid load issued on the same cycle the prescaler hits DIV-1 -> loaded value shown, no tick, next tick 4 clocks later.
- Alarm timeout: alarm = 07:30, alm_en = 1, load 07:29:59 -> alarm rises with 07:30:00 and falls with 07:30:03.
- Alarm acknowledge: repeat the timeout case, assert alm_ack at 07:30:01 -> alarm low next edge; no retrigger at 07:30:02.
- 12h mode:
  - h = 0 -> out_hour = 12, out_pm = 0.
  - h = 12 -> 12, pm = 1.
  - h = 13 -> 1, pm = 1.
  - Toggle to 24h -> out_hour = 13, pm = 0 one cycle later.
